// File: rtl/beacon_pkg.sv
// Shared types and helpers for the beacon tower decoder: FSM states, default
// widths and the wrapped pulse-width calculation.
package beacon_pkg;

  localparam int DEF_CNT_W         = 16;
  localparam int DEF_TICKS_PER_REV = 2048;

  typedef enum logic [1:0] {
    UNSYNC,
    SEARCH,
    PULSE,
    CALC
  } beacon_state_t;

  // A pulse whose fall angle is below its rise angle straddled the index mark.
  function automatic logic [31:0] wrapped_width(input logic [31:0] rise_a,
                                                input logic [31:0] fall_a,
                                                input logic [31:0] ticks);
    logic [31:0] w;
    w = fall_a - rise_a;
    if (fall_a < rise_a) w = w + ticks;
    return w;
  endfunction

endpackage

// File: rtl/beacon_tower_decoder_if.sv
// Beacon result bundle handed from the tower decoder to the SPI register-write
// FSM; the decoder drives it through the master modport.
interface beacon_tower_decoder_if #(
  parameter int CNT_W = beacon_pkg::DEF_CNT_W
);
  logic [CNT_W-1:0] beacon_rising_edge;
  logic [CNT_W-1:0] beacon_falling_edge;
  logic [CNT_W-1:0] position;
  logic             position_direction;
  logic             beacon_detection;
  logic             upd;

  modport master (
    output beacon_rising_edge, beacon_falling_edge, position,
    output position_direction, beacon_detection, upd
  );

  modport slave (
    input beacon_rising_edge, beacon_falling_edge, position,
    input position_direction, beacon_detection, upd
  );
endinterface

// File: rtl/beacon_tower_decoder_quad_step.sv
// x4 quadrature step decoder: compares the synchronised A/B pair against its
// previous value and reports a single Gray step and its direction.
module quad_step_decoder (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic step,
  output logic dir
);

  logic [1:0] ab_q, ab_d;

  always_comb ab_d = {a, b};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would create order races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ab_q <= '0;
    else        ab_q <= ab_d;
  end

  // NOTE: outputs get a default first so no path through the case leaves
  // them unassigned, which would otherwise infer a latch.
  always_comb begin
    step = 1'b0;
    dir  = 1'b0;
    case ({ab_q, a, b})
      // A leads B: 00 -> 10 -> 11 -> 01 -> 00
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
        step = 1'b1;
        dir  = 1'b1;
      end
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
        step = 1'b1;
        dir  = 1'b0;
      end
      default: ;  // no change, or an illegal double-bit jump
    endcase
  end

endmodule

// File: rtl/beacon_tower_decoder.sv
// Rotating laser tower decoder: encoder angle, index re-zero and beacon pulse
// timestamping. Optional stall watchdog enabled by defining TOWER_STALL_EN.
module beacon_tower_decoder
  import beacon_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int TICKS_PER_REV = DEF_TICKS_PER_REV,
  parameter int FILT_LEN      = 4,
  parameter int MIN_WIDTH     = 3
`ifdef TOWER_STALL_EN
  , parameter int STALL_CYCLES = 5_000_000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic laser_sig,
  input  logic laser_sync,
  input  logic cod_a,
  input  logic cod_b,
  beacon_tower_decoder_if.master bus
`ifdef TOWER_STALL_EN
  , output logic tower_stall
`endif
);

  localparam int               FC_W      = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] ANGLE_MAX = CNT_W'(TICKS_PER_REV - 1);
  localparam logic [CNT_W:0]   TICKS_W   = (CNT_W + 1)'(TICKS_PER_REV);
  localparam logic [CNT_W:0]   MIN_W     = (CNT_W + 1)'(MIN_WIDTH);

  // Bit order in the synchroniser: {laser_sig, laser_sync, cod_a, cod_b}
  logic [3:0]       meta_q, meta_d, sync_q, sync_d;
  logic             laser_s, lsync_s, a_s, b_s;
  logic             filt_q, filt_d, filt_prev_q, filt_prev_d;
  logic [FC_W-1:0]  filt_cnt_q, filt_cnt_d;
  logic             lsync_prev_q, lsync_prev_d;
  logic             step, step_dir;
  logic [CNT_W-1:0] angle_q, angle_d;
  logic             dir_q, dir_d;

  beacon_state_t    state_q, state_d;
  logic [CNT_W-1:0] rise_a_q, rise_a_d, fall_a_q, fall_a_d;
  logic             rise_dir_q, rise_dir_d;
  logic [CNT_W-1:0] rise_out_q, rise_out_d, fall_out_q, fall_out_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             pos_dir_q, pos_dir_d;
  logic             det_q, det_d, upd_q, upd_d, seen_q, seen_d;
  logic [CNT_W:0]   w, pos_sum;
  logic             filt_rise, filt_fall, sync_edge, stall_event;

  assign {laser_s, lsync_s, a_s, b_s} = sync_q;
  assign filt_rise = filt_q & ~filt_prev_q;
  assign filt_fall = ~filt_q & filt_prev_q;
  assign sync_edge = lsync_s & ~lsync_prev_q;

  quad_step_decoder u_quad (
    .clk  (clk),
    .reset(reset),
    .a    (a_s),
    .b    (b_s),
    .step (step),
    .dir  (step_dir)
  );

  // Front end: synchronisers, laser debounce, angle counter.
  always_comb begin
    meta_d       = {laser_sig, laser_sync, cod_a, cod_b};
    sync_d       = meta_q;
    filt_prev_d  = filt_q;
    lsync_prev_d = lsync_s;
    filt_d       = filt_q;
    filt_cnt_d   = '0;
    if (laser_s != filt_q) begin
      if (filt_cnt_q == FC_W'(FILT_LEN - 1)) filt_d     = laser_s;
      else                                   filt_cnt_d = filt_cnt_q + 1'b1;
    end

    angle_d = angle_q;
    dir_d   = step ? step_dir : dir_q;
    if (sync_edge) begin
      angle_d = '0;
    end else if (step) begin
      if (step_dir) angle_d = (angle_q == ANGLE_MAX) ? '0 : angle_q + 1'b1;
      else          angle_d = (angle_q == '0) ? ANGLE_MAX : angle_q - 1'b1;
    end
  end

  // Pulse FSM and registered result bundle.
  always_comb begin
    state_d    = state_q;
    rise_a_d   = rise_a_q;
    fall_a_d   = fall_a_q;
    rise_dir_d = rise_dir_q;
    rise_out_d = rise_out_q;
    fall_out_d = fall_out_q;
    pos_d      = pos_q;
    pos_dir_d  = pos_dir_q;
    det_d      = det_q;
    seen_d     = seen_q;
    upd_d      = 1'b0;

    w       = (CNT_W + 1)'(wrapped_width(32'(rise_a_q), 32'(fall_a_q), 32'(TICKS_PER_REV)));
    pos_sum = {1'b0, rise_a_q} + (w >> 1);

    if (sync_edge) begin
      seen_d = 1'b0;
      if (!seen_q) det_d = 1'b0;
    end

    case (state_q)
      UNSYNC: if (sync_edge) state_d = SEARCH;
      SEARCH: if (filt_rise) begin
        rise_a_d   = angle_q;
        rise_dir_d = dir_q;
        state_d    = PULSE;
      end
      PULSE: if (filt_fall) begin
        fall_a_d = angle_q;
        state_d  = CALC;
      end
      CALC: begin
        if (w >= MIN_W) begin
          rise_out_d = rise_a_q;
          fall_out_d = fall_a_q;
          pos_d      = (pos_sum >= TICKS_W) ? CNT_W'(pos_sum - TICKS_W) : CNT_W'(pos_sum);
          pos_dir_d  = rise_dir_q;
          det_d      = 1'b1;
          seen_d     = 1'b1;
          upd_d      = 1'b1;
        end
        state_d = SEARCH;
      end
      default: state_d = UNSYNC;
    endcase

    if (stall_event) begin
      state_d = UNSYNC;
      det_d   = 1'b0;
      upd_d   = 1'b0;
    end
  end

`ifdef TOWER_STALL_EN
  localparam int SC_W = $clog2(STALL_CYCLES + 1);

  logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            stall_q, stall_d;

  // Counter saturates at STALL_CYCLES so the stall fires once per stoppage.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    stall_d     = stall_q;
    stall_event = 1'b0;
    if (step) begin
      stall_cnt_d = '0;
      stall_d     = 1'b0;
    end else if (stall_cnt_q != SC_W'(STALL_CYCLES)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
      if (stall_cnt_q == SC_W'(STALL_CYCLES - 1)) begin
        stall_event = 1'b1;
        stall_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign tower_stall = stall_q;
`else
  assign stall_event = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q       <= '0;
      sync_q       <= '0;
      filt_q       <= 1'b0;
      filt_cnt_q   <= '0;
      filt_prev_q  <= 1'b0;
      lsync_prev_q <= 1'b0;
      angle_q      <= '0;
      dir_q        <= 1'b0;
      state_q      <= UNSYNC;
      rise_a_q     <= '0;
      fall_a_q     <= '0;
      rise_dir_q   <= 1'b0;
      rise_out_q   <= '0;
      fall_out_q   <= '0;
      pos_q        <= '0;
      pos_dir_q    <= 1'b0;
      det_q        <= 1'b0;
      upd_q        <= 1'b0;
      seen_q       <= 1'b0;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      filt_q       <= filt_d;
      filt_cnt_q   <= filt_cnt_d;
      filt_prev_q  <= filt_prev_d;
      lsync_prev_q <= lsync_prev_d;
      angle_q      <= angle_d;
      dir_q        <= dir_d;
      state_q      <= state_d;
      rise_a_q     <= rise_a_d;
      fall_a_q     <= fall_a_d;
      rise_dir_q   <= rise_dir_d;
      rise_out_q   <= rise_out_d;
      fall_out_q   <= fall_out_d;
      pos_q        <= pos_d;
      pos_dir_q    <= pos_dir_d;
      det_q        <= det_d;
      upd_q        <= upd_d;
      seen_q       <= seen_d;
    end
  end

  assign bus.beacon_rising_edge  = rise_out_q;
  assign bus.beacon_falling_edge = fall_out_q;
  assign bus.position            = pos_q;
  assign bus.position_direction  = pos_dir_q;
  assign bus.beacon_detection    = det_q;
  assign bus.upd                 = upd_q;

endmodule

// File: tb/tb_beacon_tower_decoder.sv
// Self-checking bench for beacon_tower_decoder: table of beacon pulses plus
// hand sequences for index wrap, detection expiry, reset and (TOWER_STALL_EN) stall.
module tb_beacon_tower_decoder;
  import beacon_pkg::*;

  localparam int CNT_W = 16;
  localparam int TICKS = 2048;

  logic clk        = 1'b0;
  logic reset      = 1'b0;
  logic laser_sig  = 1'b0;
  logic laser_sync = 1'b0;
  logic cod_a      = 1'b0;
  logic cod_b      = 1'b0;
`ifdef TOWER_STALL_EN
  logic tower_stall;
`endif

  beacon_tower_decoder_if #(.CNT_W(CNT_W)) bus ();

  beacon_tower_decoder #(
    .CNT_W(CNT_W), .TICKS_PER_REV(TICKS), .FILT_LEN(4), .MIN_WIDTH(3)
`ifdef TOWER_STALL_EN
    , .STALL_CYCLES(1000)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .laser_sig (laser_sig),
    .laser_sync(laser_sync),
    .cod_a     (cod_a),
    .cod_b     (cod_b),
    .bus       (bus)
`ifdef TOWER_STALL_EN
    , .tower_stall(tower_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int rise;
    int fall;
    int pos;
    bit dir;
  } exp_t;

  typedef struct {
    int   pre;     // encoder ticks before the pulse (negative = reverse)
    int   width;   // encoder ticks while the laser is high
    bit   accept;
    exp_t exp;
  } vec_t;

  exp_t sb_q[$];
  exp_t last_acc;
  vec_t vecs[5];
  int   tests        = 0;
  int   failures     = 0;
  int   upd_seen     = 0;
  int   upd_expected = 0;
  int   phase        = 0;
  int   seen_before;
  bit   glitch_hit;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every upd strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.upd === 1'b1) begin
      upd_seen++;
      if (sb_q.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL unexpected_upd: got upd with rise=%0d, expected no update",
                 bus.beacon_rising_edge);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("upd_rising_edge",  bus.beacon_rising_edge,  e.rise);
        check("upd_falling_edge", bus.beacon_falling_edge, e.fall);
        check("upd_position",     bus.position,            e.pos);
        check("upd_direction",    bus.position_direction,  e.dir);
        check("upd_detection",    bus.beacon_detection,    1);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Forward Gray order (A leads B): 00 -> 10 -> 11 -> 01
  task automatic tick(input bit fwd);
    phase = fwd ? (phase + 1) % 4 : (phase + 3) % 4;
    case (phase)
      0:       {cod_a, cod_b} = 2'b00;
      1:       {cod_a, cod_b} = 2'b10;
      2:       {cod_a, cod_b} = 2'b11;
      default: {cod_a, cod_b} = 2'b01;
    endcase
    wait_clks(4);
  endtask

  task automatic move(input int n);
    if (n >= 0) repeat (n) tick(1'b1);
    else        repeat (-n) tick(1'b0);
  endtask

  task automatic sync_pulse();
    laser_sync = 1'b1;
    wait_clks(4);
    laser_sync = 1'b0;
    wait_clks(4);
  endtask

  task automatic expect_upd(input int rise, input int fall, input int pos, input bit dir);
    exp_t e;
    e = '{rise: rise, fall: fall, pos: pos, dir: dir};
    sb_q.push_back(e);
    upd_expected++;
    last_acc = e;
  endtask

  initial begin
    vecs[0] = '{pre: 100, width: 20, accept: 1'b1, exp: '{rise: 100, fall: 120, pos: 110, dir: 1'b1}};
    vecs[1] = '{pre: 30,  width: 2,  accept: 1'b0, exp: '{rise: 0,   fall: 0,   pos: 0,   dir: 1'b0}};
    vecs[2] = '{pre: 10,  width: 3,  accept: 1'b1, exp: '{rise: 162, fall: 165, pos: 163, dir: 1'b1}};
    vecs[3] = '{pre: -20, width: 6,  accept: 1'b1, exp: '{rise: 145, fall: 151, pos: 148, dir: 1'b0}};
    vecs[4] = '{pre: 9,   width: 11, accept: 1'b1, exp: '{rise: 160, fall: 171, pos: 165, dir: 1'b1}};

    // Reset values
    wait_clks(4);
    check("reset_rising_edge",  bus.beacon_rising_edge,  0);
    check("reset_falling_edge", bus.beacon_falling_edge, 0);
    check("reset_position",     bus.position,            0);
    check("reset_direction",    bus.position_direction,  0);
    check("reset_detection",    bus.beacon_detection,    0);
    check("reset_upd",          bus.upd,                 0);
    check("reset_state",        dut.state_q,             UNSYNC);
    reset = 1'b1;
    wait_clks(4);

    sync_pulse();
    for (int i = 0; i < 5; i++) begin
      move(vecs[i].pre);
      laser_sig = 1'b1;
      wait_clks(12);
      move(vecs[i].width);
      if (vecs[i].accept)
        expect_upd(vecs[i].exp.rise, vecs[i].exp.fall, vecs[i].exp.pos, vecs[i].exp.dir);
      seen_before = upd_seen;
      laser_sig = 1'b0;
      wait_clks(16);
      check($sformatf("vec%0d_upd_count", i), upd_seen, seen_before + (vecs[i].accept ? 1 : 0));
      if (!vecs[i].accept) begin
        check($sformatf("vec%0d_rise_held", i), bus.beacon_rising_edge, last_acc.rise);
        check($sformatf("vec%0d_pos_held", i),  bus.position,           last_acc.pos);
      end
    end

    // A 3-clock glitch must never reach the filtered laser level
    seen_before = upd_seen;
    glitch_hit  = 1'b0;
    laser_sig   = 1'b1;
    wait_clks(3);
    laser_sig = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dut.filt_q) glitch_hit = 1'b1;
    end
    wait_clks(1);
    check("glitch_filtered", glitch_hit, 0);
    check("glitch_no_upd",   upd_seen,   seen_before);

    // Detection survives one index with a pulse seen, drops after an empty turn
    sync_pulse();
    check("det_kept_after_seen_rev", bus.beacon_detection, 1);
    sync_pulse();
    check("det_dropped_empty_rev",   bus.beacon_detection, 0);
    check("edges_held_after_sync",   bus.beacon_rising_edge, 160);

    // Reverse wrap from 0, then a pulse straddling the index mark
    tick(1'b0);
    check("reverse_wrap_angle", dut.angle_q, TICKS - 1);
    move(-7);
    laser_sig = 1'b1;
    wait_clks(12);
    move(4);
    sync_pulse();
    move(10);
    expect_upd(2040, 10, 1, 1'b0);
    seen_before = upd_seen;
    laser_sig = 1'b0;
    wait_clks(16);
    check("wrap_upd_count", upd_seen, seen_before + 1);

    // Reset in the middle of a pulse
    move(5);
    laser_sig = 1'b1;
    wait_clks(12);
    seen_before = upd_seen;
    reset = 1'b0;
    wait_clks(3);
    check("midreset_rising_edge",  bus.beacon_rising_edge,  0);
    check("midreset_falling_edge", bus.beacon_falling_edge, 0);
    check("midreset_position",     bus.position,            0);
    check("midreset_direction",    bus.position_direction,  0);
    check("midreset_detection",    bus.beacon_detection,    0);
    laser_sig = 1'b0;
    wait_clks(2);
    reset = 1'b1;
    wait_clks(4);
    check("midreset_state", dut.state_q, UNSYNC);
    check("midreset_no_upd", upd_seen, seen_before);

    // Pulses before the next index are ignored
    move(5);
    laser_sig = 1'b1;
    wait_clks(12);
    move(10);
    laser_sig = 1'b0;
    wait_clks(16);
    check("unsync_pulse_ignored", upd_seen, seen_before);
    check("unsync_rise_still_0",  bus.beacon_rising_edge, 0);

    sync_pulse();
    move(20);
    laser_sig = 1'b1;
    wait_clks(12);
    move(8);
    expect_upd(20, 28, 24, 1'b1);
    laser_sig = 1'b0;
    wait_clks(16);
    check("resync_upd_count", upd_seen, seen_before + 1);

`ifdef TOWER_STALL_EN
    wait_clks(1100);
    check("stall_asserted",    tower_stall,          1);
    check("stall_det_cleared", bus.beacon_detection, 0);
    check("stall_state",       dut.state_q,          UNSYNC);
    tick(1'b1);
    check("stall_cleared",     tower_stall,          0);
`endif

    check("scoreboard_drained", sb_q.size(), 0);
    check("total_upd_count",    upd_seen,    upd_expected);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/beacon_tower_decoder.md
Name: beacon_tower_decoder

Overview:
- Decodes the rotating laser tower: quadrature-decodes the tower encoder into an angle, re-zeroes the angle on the once-per-turn sync, and timestamps the beacon pulse edges.
- Produces beacon_rising_edge, beacon_falling_edge, position, position_direction and beacon_detection.
- These outputs feed directly into the SPI register-write FSM at addresses 1 and 2.
- Sits between the GPIO_1 laser pins and the SPI register-write FSM.

Parameters:
- CNT_W, 16, width of angle and edge values
- TICKS_PER_REV, 2048, encoder counts per tower revolution; angle modulus
- FILT_LEN, 4, clocks the synchronised laser input must be stable before an edge is accepted
- MIN_WIDTH, 3, minimum beacon pulse width in ticks; shorter pulses are rejected
- STALL_CYCLES, 5_000_000, optional stall timeout in clocks (100 ms at 50 MHz)

Ports:
- clk  in  1  system clock, CLOCK_50
- reset  in  1  asynchronous, active-low reset
- laser_sig  in  1  raw beacon photodiode (Laser_signal)
- laser_sync  in  1  raw once-per-turn index (Laser_sync)
- cod_a  in  1  raw tower encoder A
- cod_b  in  1  raw tower encoder B
- beacon_rising_edge  out  CNT_W  angle latched at the accepted pulse rise
- beacon_falling_edge  out  CNT_W  angle latched at the accepted pulse fall
- position  out  CNT_W  beacon centre angle
- position_direction  out  1  rotation direction during the last pulse; 1 = A leads B
- beacon_detection  out  1  a valid pulse was seen in the current or previous revolution
- upd  out  1  one-cycle strobe when all of the above update together
- tower_stall  out  1  present only with TOWER_STALL_EN

Behaviour:
- Reset: all outputs are 0, the angle is 0, the FSM is in UNSYNC, and the filter counter is 0.
- Input synchronisation: all four raw inputs pass through 2-FF synchronisers. The laser input is then filtered: filt_laser takes the new level only after FILT_LEN consecutive equal samples. Synchronisation plus filtering costs 2+FILT_LEN clocks.
- Quadrature decode (x4):
  - Valid Gray transitions give +1 or −1. Illegal double-bit changes are ignored.
  - The angle wraps modulo TICKS_PER_REV: TICKS_PER_REV−1 +1 → 0, and 0 −1 → TICKS_PER_REV−1.
- Sync:
  - The rising edge of synced laser_sync forces the angle to 0 in that cycle, taking priority over a simultaneous encoder step.
  - At each sync edge, beacon_detection is cleared if no pulse was accepted since the previous sync edge.
- FSM states:
  - UNSYNC: ignore the laser; on the first sync edge go to SEARCH.
  - SEARCH: on filt_laser rising, capture rise_a = angle, record the current rotation direction, and go to PULSE.
  - PULSE: on filt_laser falling, capture fall_a = angle and go to CALC.
  - CALC (one cycle), with all arithmetic in CNT_W+1 bits:
    - w = fall_a − rise_a, plus TICKS_PER_REV if fall_a < rise_a (the pulse straddles sync).
    - If w < MIN_WIDTH: discard the pulse, leave outputs unchanged, no upd.
    - Otherwise:
      - position = (rise_a + w/2) mod TICKS_PER_REV; w/2 truncates.
      - Load the edge outputs with rise_a and fall_a.
      - Set beacon_detection, pulse upd, and mark the revolution as "seen".
    - Return to SEARCH.
- Outputs are registered; upd asserts 1 cycle after the filtered fall.
- Sync edge during PULSE: the angle resets but the pulse continues. The wrap rule above handles it.
- Direction reversal during a pulse: position_direction reflects the direction at the rise. Arithmetic is unchanged.
- Asynchronous reset mid-pulse: the FSM returns to UNSYNC and no upd is issued.

Optional Feature:
- TOWER_STALL_EN defined:
  - A counter counts clocks since the last valid encoder step.
  - At STALL_CYCLES it sets tower_stall, clears beacon_detection and forces the FSM to UNSYNC.
  - tower_stall clears on the next encoder step.
- Undefined: no counter, no tower_stall port, and the tower is never considered stalled.

Decomposition:
- Package beacon_pkg:
  - FSM enum beacon_state_t {UNSYNC, SEARCH, PULSE, CALC}.
  - Default CNT_W and TICKS_PER_REV localparams.
  - A function for wrapped-width computation.
- Sub-module quad_step_decoder:
  - Inputs: synced A and B.
  - Outputs: step, dir.
  - Behaviour: registered previous AB, Gray transition table.

Test Plan:
- Sync, then 100 forward ticks, then laser high for 20 ticks, then low → rising_edge=100, falling_edge=120, position=110, position_direction=1, beacon_detection=1, exactly one upd.
- Rise at angle 2040, sync, fall at angle 10 (TICKS_PER_REV=2048) → w=18, position=1, rising_edge=2040, falling_edge=10.
- Laser high for only 2 ticks → no upd, outputs unchanged. Then laser glitch lasting 3 clocks → no rise detected.
- Two consecutive sync edges with no beacon pulse → beacon_detection drops to 0 at the second sync edge.
- Reverse rotation from angle 0 for one step → angle=2047. Reset asserted during PULSE → all outputs 0, FSM in UNSYNC, and pulses before the next sync are ignored.
- With TOWER_STALL_EN and STALL_CYCLES=1000: no encoder steps for 1000 clocks → tower_stall=1, beacon_detection=0. One tick → tower_stall=0.
